// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared MIG command encodings, port counts and arbiter state type
package mem_pkg;

    localparam logic [2:0] MIG_CMD_READ    = 3'b001;
    localparam logic [2:0] MIG_CMD_WRITE   = 3'b000;

    localparam int NUM_RD_PORTS    = 2;
    localparam int BEATS_PER_BURST = 2;
    localparam int ADDR_W          = 29;
    localparam int DATA_W          = 256;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CMD  = 1'b1
    } arb_state_e;

    // MIG bursts start on an 8-column boundary; the low three address bits are ignored.
    function automatic logic [ADDR_W-1:0] burst_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:3], 3'b000};
    endfunction

endpackage

// File: rtl/SingleClockFifo.sv
// rtl/SingleClockFifo.sv - single-clock FIFO with first-word-fall-through read port
module SingleClockFifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    // Extra pointer bit distinguishes full from empty when the indices coincide.
    always_comb begin
        empty_o    = (wr_ptr_q == rd_ptr_q);
        full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_push    = push_i && !full_o;
        do_pop     = pop_i && !empty_o;
        wr_ptr_d   = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        pop_data_o = mem_q[rd_ptr_q[AW-1:0]];
    end

    // Pointer registers; clearing them empties the FIFO.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: entries are only read once written.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        end
    end

endmodule

// File: rtl/mem_read_arbiter.sv
// rtl/mem_read_arbiter.sv - two-port round-robin MIG read arbiter (optional counters: MEM_READ_ARBITER_PERF_EN)
module mem_read_arbiter
    import mem_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 16
) (
    input  logic                                clk_ram,
    input  logic                                rst_n,
    input  logic [NUM_RD_PORTS-1:0]             req_valid,
    input  logic [NUM_RD_PORTS-1:0][ADDR_W-1:0] req_addr,
    output logic [NUM_RD_PORTS-1:0]             req_ready,
    output logic [NUM_RD_PORTS-1:0]             rsp_valid,
    output logic [DATA_W-1:0]                   rsp_data,
    output logic                                rsp_last,
    output logic [ADDR_W-1:0]                   app_addr,
    output logic [2:0]                          app_cmd,
    output logic                                app_en,
    input  logic                                app_rdy,
    input  logic [DATA_W-1:0]                   app_rd_data,
    input  logic                                app_rd_data_valid,
    input  logic                                app_rd_data_end,
    output logic                                busy,
    output logic                                rd_unexpected
`ifdef MEM_READ_ARBITER_PERF_EN
    ,
    output logic [31:0]                         perf_cmds,
    output logic [31:0]                         perf_beats,
    output logic [31:0]                         perf_stall_cycles
`endif
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    arb_state_e        state_q, state_d;
    logic              rr_q, rr_d;
    logic [CNT_W-1:0]  outstanding_q, outstanding_d;
    logic              app_en_q, app_en_d;
    logic [ADDR_W-1:0] app_addr_q, app_addr_d;
    logic [2:0]        app_cmd_q, app_cmd_d;
    logic              cmd_port_q, cmd_port_d;
    logic [NUM_RD_PORTS-1:0] rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_last_q, rsp_last_d;
    logic              rd_unexpected_q, rd_unexpected_d;

    logic              grant;
    logic              gnt_port;
    logic              issue;
    logic              tag_head;
    logic              tag_empty;
    logic              tag_full;
    logic              beat_routed;
    logic              burst_done;

    // Round-robin grant: preferred port first, otherwise the other requester.
    always_comb begin
        gnt_port  = req_valid[rr_q] ? rr_q : ~rr_q;
        grant     = rst_n && (state_q == ST_IDLE) && (|req_valid) &&
                    (outstanding_q < MAX_CNT) && !tag_full;
        req_ready = '0;
        if (grant) begin
            req_ready[gnt_port] = 1'b1;
        end
    end

    assign issue = app_en_q && app_rdy;

    // Command FSM: latch the granted request, hold it on the MIG bus until accepted.
    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        app_en_d   = app_en_q;
        app_addr_d = app_addr_q;
        app_cmd_d  = app_cmd_q;
        cmd_port_d = cmd_port_q;
        case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    state_d    = ST_CMD;
                    rr_d       = ~gnt_port;
                    app_en_d   = 1'b1;
                    app_addr_d = burst_align(req_addr[gnt_port]);
                    app_cmd_d  = MIG_CMD_READ;
                    cmd_port_d = gnt_port;
                end
            end
            ST_CMD: begin
                if (issue) begin
                    state_d  = ST_IDLE;
                    app_en_d = 1'b0;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                app_en_d = 1'b0;
            end
        endcase
    end

    // Return path: steer each beat to the port whose tag heads the FIFO; beats with no tag are dropped.
    always_comb begin
        beat_routed     = app_rd_data_valid && !tag_empty;
        burst_done      = beat_routed && app_rd_data_end;
        rsp_valid_d     = '0;
        if (beat_routed) begin
            rsp_valid_d[tag_head] = 1'b1;
        end
        rsp_data_d      = beat_routed ? app_rd_data : rsp_data_q;
        rsp_last_d      = beat_routed && app_rd_data_end;
        rd_unexpected_d = rd_unexpected_q || (app_rd_data_valid && tag_empty);
    end

    // Outstanding burst count; simultaneous issue and completion cancel out.
    always_comb begin
        outstanding_d = outstanding_q;
        case ({issue, burst_done})
            2'b10:   outstanding_d = outstanding_q + 1'b1;
            2'b01:   outstanding_d = outstanding_q - 1'b1;
            default: outstanding_d = outstanding_q;
        endcase
    end

    // State, command and response registers.
    always_ff @(posedge clk_ram or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            rr_q            <= 1'b0;
            outstanding_q   <= '0;
            app_en_q        <= 1'b0;
            app_addr_q      <= '0;
            app_cmd_q       <= '0;
            cmd_port_q      <= 1'b0;
            rsp_valid_q     <= '0;
            rsp_data_q      <= '0;
            rsp_last_q      <= 1'b0;
            rd_unexpected_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            rr_q            <= rr_d;
            outstanding_q   <= outstanding_d;
            app_en_q        <= app_en_d;
            app_addr_q      <= app_addr_d;
            app_cmd_q       <= app_cmd_d;
            cmd_port_q      <= cmd_port_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_data_q      <= rsp_data_d;
            rsp_last_q      <= rsp_last_d;
            rd_unexpected_q <= rd_unexpected_d;
        end
    end

    SingleClockFifo #(
        .WIDTH (1),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk_i       (clk_ram),
        .rst_ni      (rst_n),
        .push_i      (issue),
        .push_data_i (cmd_port_q),
        .pop_i       (burst_done),
        .pop_data_o  (tag_head),
        .empty_o     (tag_empty),
        .full_o      (tag_full)
    );

    assign app_en        = app_en_q;
    assign app_addr      = app_addr_q;
    assign app_cmd       = app_cmd_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = rsp_data_q;
    assign rsp_last      = rsp_last_q;
    assign rd_unexpected = rd_unexpected_q;
    assign busy          = (state_q == ST_CMD) || (outstanding_q != '0);

`ifdef MEM_READ_ARBITER_PERF_EN
    logic [31:0] perf_cmds_q, perf_beats_q, perf_stall_q;

    // Free-running wrap-around event counters.
    always_ff @(posedge clk_ram or negedge rst_n) begin
        if (!rst_n) begin
            perf_cmds_q  <= '0;
            perf_beats_q <= '0;
            perf_stall_q <= '0;
        end else begin
            if (issue)                 perf_cmds_q  <= perf_cmds_q + 32'd1;
            if (beat_routed)           perf_beats_q <= perf_beats_q + 32'd1;
            if (app_en_q && !app_rdy)  perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_cmds         = perf_cmds_q;
    assign perf_beats        = perf_beats_q;
    assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: tb/tb_mem_read_arbiter.sv
// tb/tb_mem_read_arbiter.sv - scoreboard bench for mem_read_arbiter
module tb_mem_read_arbiter;

    logic              clk_ram = 1'b0;
    logic              rst_n = 1'b0;
    logic [1:0]        req_valid = '0;
    logic [1:0][28:0]  req_addr = '0;
    logic [1:0]        req_ready;
    logic [1:0]        rsp_valid;
    logic [255:0]      rsp_data;
    logic              rsp_last;
    logic [28:0]       app_addr;
    logic [2:0]        app_cmd;
    logic              app_en;
    logic              app_rdy = 1'b0;
    logic [255:0]      app_rd_data = '0;
    logic              app_rd_data_valid = 1'b0;
    logic              app_rd_data_end = 1'b0;
    logic              busy;
    logic              rd_unexpected;
`ifdef MEM_READ_ARBITER_PERF_EN
    logic [31:0]       perf_cmds, perf_beats, perf_stall_cycles;
`endif

    mem_read_arbiter #(.MAX_OUTSTANDING(16)) dut (
        .clk_ram           (clk_ram),
        .rst_n             (rst_n),
        .req_valid         (req_valid),
        .req_addr          (req_addr),
        .req_ready         (req_ready),
        .rsp_valid         (rsp_valid),
        .rsp_data          (rsp_data),
        .rsp_last          (rsp_last),
        .app_addr          (app_addr),
        .app_cmd           (app_cmd),
        .app_en            (app_en),
        .app_rdy           (app_rdy),
        .app_rd_data       (app_rd_data),
        .app_rd_data_valid (app_rd_data_valid),
        .app_rd_data_end   (app_rd_data_end),
        .busy              (busy),
        .rd_unexpected     (rd_unexpected)
`ifdef MEM_READ_ARBITER_PERF_EN
        ,
        .perf_cmds         (perf_cmds),
        .perf_beats        (perf_beats),
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    always #5 clk_ram = ~clk_ram;

    typedef struct {
        logic [1:0]   v;
        logic [255:0] d;
        logic         l;
    } rsp_t;

    logic         exp_gnt[$];
    logic [28:0]  exp_cmd[$];
    rsp_t         exp_rsp[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: event with no expectation or bound expired", name);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a grant, command or response.
    logic         mon_g;
    logic [28:0]  mon_a;
    rsp_t         mon_e;
    always @(negedge clk_ram) begin
        if (rst_n) begin
            if (req_ready != 2'b00) begin
                if (exp_gnt.size() == 0) fail("gnt_unexpected");
                else begin
                    mon_g = exp_gnt.pop_front();
                    chk("gnt_port", req_ready, 2'b01 << mon_g);
                end
            end
            if (app_en && app_rdy) begin
                if (exp_cmd.size() == 0) fail("cmd_unexpected");
                else begin
                    mon_a = exp_cmd.pop_front();
                    chk("cmd_addr", app_addr, mon_a);
                    chk("cmd_code", app_cmd, 3'b001);
                end
            end
            if (rsp_valid != 2'b00) begin
                if (exp_rsp.size() == 0) fail("rsp_unexpected");
                else begin
                    mon_e = exp_rsp.pop_front();
                    chk("rsp_valid", rsp_valid, mon_e.v);
                    chk("rsp_last", rsp_last, mon_e.l);
                    chk("rsp_data", rsp_data, mon_e.d);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_ram);
        #1;
    endtask

    task automatic do_reset();
        chk("queues_drained", exp_gnt.size() + exp_cmd.size() + exp_rsp.size(), 0);
        rst_n = 1'b0;
        req_valid = '0;
        app_rdy = 1'b0;
        app_rd_data_valid = 1'b0;
        app_rd_data_end = 1'b0;
        exp_gnt.delete();
        exp_cmd.delete();
        exp_rsp.delete();
        repeat (3) step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic wait_grant(input string name);
        bit got = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk_ram);
            if (req_ready != 2'b00) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) fail(name);
    endtask

    task automatic send_burst(input logic [1:0] port_oh, input logic [255:0] d0, input logic [255:0] d1);
        exp_rsp.push_back('{port_oh, d0, 1'b0});
        exp_rsp.push_back('{port_oh, d1, 1'b1});
        app_rd_data_valid = 1'b1;
        app_rd_data = d0;
        app_rd_data_end = 1'b0;
        step();
        app_rd_data = d1;
        app_rd_data_end = 1'b1;
        step();
        app_rd_data_valid = 1'b0;
        app_rd_data_end = 1'b0;
    endtask

    initial begin
        bit seen;

        // Reset state, with requests already asserted.
        rst_n = 1'b0;
        req_valid = 2'b11;
        app_rdy = 1'b1;
        step();
        @(negedge clk_ram);
        chk("rst_app_en", app_en, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_unexpected", rd_unexpected, 0);
        chk("rst_app_addr", app_addr, 0);
        do_reset();

        // Single request: accept at N, command at N+1 with aligned address.
        app_rdy = 1'b1;
        req_addr[0] = 29'h0000123F;
        req_valid = 2'b01;
        exp_gnt.push_back(1'b0);
        exp_cmd.push_back(29'h00001238);
        @(negedge clk_ram);
        chk("t1_ready_n", req_ready, 2'b01);
        step();
        req_valid = 2'b00;
        @(negedge clk_ram);
        chk("t1_app_en", app_en, 1);
        chk("t1_app_addr", app_addr, 29'h00001238);
        chk("t1_app_cmd", app_cmd, 3'b001);
        step();
        @(negedge clk_ram);
        chk("t1_busy_outstanding", busy, 1);
        step();
        send_burst(2'b01, 256'hA0, 256'hA1);
        step();
        @(negedge clk_ram);
        chk("t1_idle_after", busy, 0);
        step();

        // Alternating grants with both ports requesting continuously.
        do_reset();
        app_rdy = 1'b1;
        req_addr[0] = 29'h00000100;
        req_addr[1] = 29'h0000020D;
        for (int i = 0; i < 4; i++) begin
            exp_gnt.push_back(i[0]);
            exp_cmd.push_back(i[0] ? 29'h00000208 : 29'h00000100);
        end
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) wait_grant("alt_grant_timeout");
        step();
        req_valid = 2'b00;
        step();
        step();
        for (int i = 0; i < 4; i++)
            send_burst(i[0] ? 2'b10 : 2'b01, 256'h100 + 256'(2 * i), 256'h101 + 256'(2 * i));
        step();
        @(negedge clk_ram);
        chk("alt_busy_drained", busy, 0);
        step();

        // Stall: command held stable while app_rdy is low, no further grant.
        do_reset();
        app_rdy = 1'b0;
        req_addr[0] = 29'h00002000;
        req_addr[1] = 29'h00003000;
        req_valid = 2'b01;
        exp_gnt.push_back(1'b0);
        exp_cmd.push_back(29'h00002000);
        wait_grant("stall_grant_timeout");
        step();
        req_valid = 2'b11;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_ram);
            chk("stall_app_en", app_en, 1);
            chk("stall_app_addr", app_addr, 29'h00002000);
            chk("stall_no_grant", req_ready, 0);
        end
        step();
        app_rdy = 1'b1;
        req_valid = 2'b00;
        step();
        step();
        chk("stall_en_dropped", app_en, 0);
`ifdef MEM_READ_ARBITER_PERF_EN
        chk("perf_stall_cycles", perf_stall_cycles, 5);
        chk("perf_cmds", perf_cmds, 1);
`endif

        // Outstanding limit: 16 issues, no 17th until a burst completes.
        do_reset();
        app_rdy = 1'b1;
        req_addr[0] = 29'h00000040;
        for (int i = 0; i < 16; i++) begin
            exp_gnt.push_back(1'b0);
            exp_cmd.push_back(29'h00000040);
        end
        req_valid = 2'b01;
        for (int i = 0; i < 16; i++) wait_grant("limit_grant_timeout");
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk_ram);
            if (req_ready != 2'b00) seen = 1'b1;
        end
        chk("limit_no_17th", seen, 0);
        chk("limit_busy", busy, 1);
        step();
        exp_gnt.push_back(1'b0);
        exp_cmd.push_back(29'h00000040);
        send_burst(2'b01, 256'hBEEF0, 256'hBEEF1);
        @(negedge clk_ram);
        chk("limit_grant_resume", req_ready, 2'b01);
        step();
        req_valid = 2'b00;
        step();
        step();

        // Response routing by tag order: port 1 then port 0.
        do_reset();
        app_rdy = 1'b1;
        req_addr[1] = 29'h00000080;
        req_addr[0] = 29'h000000C0;
        exp_gnt.push_back(1'b1);
        exp_cmd.push_back(29'h00000080);
        exp_gnt.push_back(1'b0);
        exp_cmd.push_back(29'h000000C0);
        req_valid = 2'b10;
        wait_grant("order_grant1_timeout");
        step();
        req_valid = 2'b01;
        wait_grant("order_grant0_timeout");
        step();
        req_valid = 2'b00;
        step();
        step();
        send_burst(2'b10, 256'hC0DE_0000, 256'hC0DE_0001);
        send_burst(2'b01, {4{64'h1234_5678_9ABC_DEF0}}, {4{64'h0FED_CBA9_8765_4321}});
        step();
        @(negedge clk_ram);
        chk("order_busy_drained", busy, 0);
        chk("order_no_unexpected", rd_unexpected, 0);
        step();

        // Unexpected beat with an empty tag FIFO.
        do_reset();
        chk("unexp_clear", rd_unexpected, 0);
        app_rd_data = 256'hDEAD;
        app_rd_data_valid = 1'b1;
        app_rd_data_end = 1'b1;
        step();
        app_rd_data_valid = 1'b0;
        app_rd_data_end = 1'b0;
        @(negedge clk_ram);
        chk("unexp_flag", rd_unexpected, 1);
        chk("unexp_no_rsp", rsp_valid, 0);
        chk("unexp_outstanding", busy, 0);
        step();
        step();
        chk("unexp_sticky", rd_unexpected, 1);

        // Reset mid-burst: later beats are treated as unexpected.
        do_reset();
        chk("midrst_unexp_cleared", rd_unexpected, 0);
        app_rdy = 1'b1;
        req_addr[0] = 29'h00000000;
        exp_gnt.push_back(1'b0);
        exp_cmd.push_back(29'h00000000);
        req_valid = 2'b01;
        wait_grant("midrst_grant_timeout");
        step();
        req_valid = 2'b00;
        step();
        do_reset();
        app_rd_data_valid = 1'b1;
        app_rd_data_end = 1'b1;
        step();
        app_rd_data_valid = 1'b0;
        app_rd_data_end = 1'b0;
        @(negedge clk_ram);
        chk("midrst_unexpected", rd_unexpected, 1);
        chk("midrst_no_rsp", rsp_valid, 0);
        step();

        chk("final_queues_drained", exp_gnt.size() + exp_cmd.size() + exp_rsp.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/mem_read_arbiter.md
MEM_READ_ARBITER -- requirements
Module: mem_read_arbiter

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 16, meaning the maximum number of read bursts issued to the MIG whose data has not yet returned (power of two, 2..64).
REQ-002 SHALL have ports clk_ram (in, 1, sole clock) and rst_n (in, 1, asynchronous active-low reset); one clock, asynchronous active-low reset, as already decided.
REQ-003 SHALL have ports req_valid (in, 2, per-port read request) and req_addr[p] (in, 29 each, burst start address).
REQ-004 SHALL have port req_ready (out, 2, per-port request accepted this cycle when valid is also high).
REQ-005 SHALL have ports rsp_valid (out, 2, per-port data beat), rsp_data (out, 256, shared data bus) and rsp_last (out, 1, second beat of burst).
REQ-006 SHALL have ports app_addr (out, 29), app_cmd (out, 3), app_en (out, 1) and app_rdy (in, 1): the MIG command channel.
REQ-007 SHALL have ports app_rd_data (in, 256), app_rd_data_valid (in, 1) and app_rd_data_end (in, 1).
REQ-008 SHALL have ports busy (out, 1, outstanding count nonzero or command pending) and rd_unexpected (out, 1, sticky error).

Function
REQ-009 SHALL issue only read commands: app_cmd = 3'b001 whenever app_en is high.
REQ-010 SHALL force app_addr[2:0] to 0 and pass req_addr[28:3] unchanged.
REQ-011 SHALL use two states, IDLE and CMD: IDLE -> CMD on grant; CMD -> IDLE when app_en && app_rdy.
REQ-012 SHALL grant in IDLE only, and only when outstanding < MAX_OUTSTANDING.
REQ-013 SHALL grant the round-robin pointer's port if it is valid, otherwise the other valid port.
REQ-014 SHALL assert req_ready combinationally for exactly the granted port in the grant cycle, and for no port otherwise.
REQ-015 SHALL flip the round-robin pointer to the port not granted, on each grant.
REQ-016 SHALL register the grant so that app_en, app_addr and app_cmd are valid on the cycle after the accept.
REQ-017 SHALL hold app_en, app_addr and app_cmd stable while app_rdy is low; the command issues when app_en && app_rdy.
REQ-018 SHALL push the granted port ID into a tag FIFO on issue.
REQ-019 SHALL, on each app_rd_data_valid, route the beat to the port at the head of the tag FIFO with 1-cycle latency: rsp_valid one-hot, rsp_data registered, rsp_last = app_rd_data_end.
REQ-020 SHALL pop the tag FIFO when app_rd_data_valid && app_rd_data_end.
REQ-021 SHALL apply no backpressure on responses; clients must accept every beat.
REQ-022 SHALL track outstanding (width log2(MAX_OUTSTANDING)+1): +1 on issue, -1 on final beat; if both happen in the same cycle, unchanged.
REQ-023 SHALL, when app_rd_data_valid occurs with the tag FIFO empty, set rd_unexpected, drop the beat (no rsp_valid) and leave outstanding unchanged.
REQ-024 SHALL drive busy = (state == CMD) || (outstanding != 0).

Reset
REQ-025 SHALL, on rst_n low, asynchronously clear app_en, app_addr, app_cmd, rsp_valid, rsp_data, rsp_last, req_ready, rd_unexpected, busy, outstanding, the round-robin pointer (port 0) and the tag FIFO, and enter IDLE.
REQ-026 SHALL, on reset mid-burst, discard in-flight tags; beats arriving after reset are treated as unexpected.

Configuration
REQ-027 SHALL, with macro MEM_READ_ARBITER_PERF_EN defined, add outputs perf_cmds (32), perf_beats (32) and perf_stall_cycles (32), counting issues, routed beats and cycles with app_en && !app_rdy; counters wrap and are reset by rst_n.
REQ-028 SHALL, without MEM_READ_ARBITER_PERF_EN, omit those ports and counters entirely.

Structure
REQ-029 SHALL place MIG command encodings (READ = 3'b001, WRITE = 3'b000), NUM_RD_PORTS = 2 and the beats-per-burst constant (2) in shared package mem_pkg.
REQ-030 SHALL implement the tag FIFO as one sub-module, SingleClockFifo (width 1, depth MAX_OUTSTANDING), instantiated once.

Verification
REQ-031 SHALL verify: port 0 valid, addr 0x0000123F, app_rdy = 1 -> req_ready[0] at cycle N, app_en at N+1 with app_addr 0x00001238, app_cmd 1.
REQ-032 SHALL verify: both ports valid continuously -> grants alternate 0,1,0,1 (4 issues).
REQ-033 SHALL verify: app_rdy low for 5 cycles while app_en is high -> command held stable, no new grant, perf_stall_cycles = 5.
REQ-034 SHALL verify: 16 issues with no returned data -> no 17th grant; one final beat returns -> grant resumes the next IDLE cycle.
REQ-035 SHALL verify: issues from port 1 then port 0, followed by 4 returned beats -> rsp_valid = 2'b10, 2'b10, 2'b01, 2'b01 with rsp_last on beats 2 and 4.
REQ-036 SHALL verify: app_rd_data_valid pulses after reset with no issue -> rd_unexpected = 1, no rsp_valid, outstanding = 0.
